// File: rtl/tile_board_engine_if.sv
// Move-command handshake between a controller and the 2048 board engine.
//   move_valid : controller requests a move
//   move_dir   : 0=up, 1=down, 2=left, 3=right
//   move_ready : engine is idle and will take the move on this cycle
interface tile_board_engine_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/tile_board_engine.sv
// Game-state writer for the 4x4 2048 grid read by the VGA tile renderer.
// Holds 16 tile exponents (0 = empty, e = 2^e), executes moves one line per
// cycle, spawns tiles from an LFSR, and tracks score / won / lost.
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   mif (slave)           move_valid / move_dir / move_ready handshake
//   new_game              pulse: clear board and spawn two tiles
//   ld_en/ld_idx/ld_val   debug tile write, honoured only when idle
//   rd_idx -> rd_val      combinational tile read port
//   board                 flat board, tile i at [4i+3:4i]
//   score                 saturating score
//   moved, done           move result and one-cycle completion pulse
//   won, lost             sticky 2048 flag, no-move-possible flag
// Tile index: idx = 4*col + row.
module tile_board_engine #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 20
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  tile_board_engine_if.slave mif,
  input  logic               new_game,
  input  logic               ld_en,
  input  logic [3:0]         ld_idx,
  input  logic [3:0]         ld_val,
  input  logic [3:0]         rd_idx,
  output logic [3:0]         rd_val,
  output logic [63:0]        board,
  output logic [SCORE_W-1:0] score,
  output logic               moved,
  output logic               done,
  output logic               won,
  output logic               lost
);

  typedef enum logic [1:0] {S_IDLE, S_SLIDE, S_SPAWN, S_CHECK} state_t;

  state_t              state_q, state_d;
  logic [63:0]         board_q;
  logic [SCORE_W-1:0]  score_q;
  logic [15:0]         lfsr_q;
  logic [1:0]          dir_q, line_q, spawn_cnt_q;
  logic [3:0]          ptr_q, miss_q;
  logic                moved_q, done_q, won_q, lost_q;

  logic                accept, line_changed, spawn_hit, won_now, lost_now;
  logic [15:0]         line_in, line_out;
  logic [31:0]         gain;
  logic [63:0]         slide_board;

  // Board index of cell k (k=0 is the head) of line l for a direction.
  // 3-k is simply ~k on two bits.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir,
                                          input logic [1:0] l,
                                          input logic [1:0] k);
    case (dir)
      2'd0:    return {l, k};
      2'd1:    return {l, ~k};
      2'd2:    return {k, l};
      default: return {~k, l};
    endcase
  endfunction

  function automatic logic [3:0] merge_exp(input logic [3:0] e);
    return (e == 4'hF) ? 4'hF : e + 4'd1;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [31:0] b);
    logic [SCORE_W+32:0] s;
    s = {33'd0, a} + {{(SCORE_W+1){1'b0}}, b};
    if (|s[SCORE_W+32:SCORE_W]) return '1;
    return s[SCORE_W-1:0];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Compress toward the head, then merge equal pairs scanning from the head.
  // A slot consumed by a merge is skipped, so a merged tile cannot merge again.
  // comp carries a fifth always-empty slot so the look-ahead never leaves range.
  function automatic void slide_line(input  logic [15:0] cin,
                                     output logic [15:0] res,
                                     output logic [31:0] g);
    logic [19:0] comp;
    logic [3:0]  e;
    logic        skip;
    int          n;
    comp = '0;
    n    = 0;
    for (int k = 0; k < 4; k++) begin
      if (cin[4*k +: 4] != 4'd0) begin
        comp[4*n +: 4] = cin[4*k +: 4];
        n++;
      end
    end
    res  = '0;
    g    = '0;
    n    = 0;
    skip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = comp[4*k +: 4];
      if (skip) begin
        skip = 1'b0;
      end else if (e != 4'd0) begin
        if (e == comp[4*k+4 +: 4]) begin
          res[4*n +: 4] = merge_exp(e);
          g    = g + (32'd1 << ({1'b0, e} + 5'd1));
          skip = 1'b1;
        end else begin
          res[4*n +: 4] = e;
        end
        n++;
      end
    end
  endfunction

  always_comb begin
    line_in = '0;
    for (int k = 0; k < 4; k++)
      line_in[4*k +: 4] = board_q[{cell_idx(dir_q, line_q, 2'(k)), 2'b00} +: 4];
    slide_line(line_in, line_out, gain);
    slide_board = board_q;
    for (int k = 0; k < 4; k++)
      slide_board[{cell_idx(dir_q, line_q, 2'(k)), 2'b00} +: 4] = line_out[4*k +: 4];
  end

  assign line_changed = (line_out != line_in);
  assign spawn_hit    = (board_q[{ptr_q, 2'b00} +: 4] == 4'd0);

  // End-of-move status; the zero-padded copy lets the neighbour compare run
  // past the last row/column without leaving the vector.
  always_comb begin
    logic [79:0] ext;
    logic [3:0]  t;
    logic        any_empty, any_pair;
    ext       = {16'd0, board_q};
    t         = '0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    won_now   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      t = ext[4*i +: 4];
      if (t == 4'd0)  any_empty = 1'b1;
      if (t >= 4'd11) won_now   = 1'b1;
      if (((i & 3) != 3) && (t == ext[4*i+4 +: 4]))  any_pair = 1'b1;
      if ((i < 12) && (t == ext[4*i+16 +: 4]))       any_pair = 1'b1;
    end
    lost_now = !any_empty && !any_pair;
  end

  assign accept = mif.move_valid && mif.move_ready;

  // FSM: state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= S_SPAWN;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = S_SPAWN;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_SLIDE;
        S_SLIDE: if (line_q == 2'd3)
                   state_d = (moved_q || line_changed) ? S_SPAWN : S_CHECK;
        // A full board gives up after sixteen consecutive occupied probes.
        S_SPAWN: if (spawn_hit ? (spawn_cnt_q == 2'd1) : (miss_q == 4'hF))
                   state_d = S_CHECK;
        S_CHECK: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    mif.move_ready = (state_q == S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      board_q     <= '0;
      score_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      dir_q       <= 2'd0;
      line_q      <= 2'd0;
      moved_q     <= 1'b0;
      ptr_q       <= LFSR_SEED[3:0];
      spawn_cnt_q <= 2'd2;
      miss_q      <= 4'd0;
      done_q      <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      done_q <= 1'b0;
      if (new_game) begin
        board_q     <= '0;
        score_q     <= '0;
        won_q       <= 1'b0;
        lost_q      <= 1'b0;
        moved_q     <= 1'b0;
        ptr_q       <= lfsr_q[3:0];
        spawn_cnt_q <= 2'd2;
        miss_q      <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              dir_q   <= mif.move_dir;
              line_q  <= 2'd0;
              moved_q <= 1'b0;
            end else if (ld_en) begin
              board_q[{ld_idx, 2'b00} +: 4] <= ld_val;
            end
          end
          S_SLIDE: begin
            board_q <= slide_board;
            score_q <= sat_add(score_q, gain);
            moved_q <= moved_q | line_changed;
            line_q  <= line_q + 2'd1;
            if (line_q == 2'd3) begin
              ptr_q       <= lfsr_q[3:0];
              spawn_cnt_q <= 2'd1;
              miss_q      <= 4'd0;
            end
          end
          S_SPAWN: begin
            if (spawn_hit) begin
              board_q[{ptr_q, 2'b00} +: 4] <= (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
              spawn_cnt_q <= spawn_cnt_q - 2'd1;
              miss_q      <= 4'd0;
            end else begin
              ptr_q  <= ptr_q + 4'd1;
              miss_q <= miss_q + 4'd1;
            end
          end
          S_CHECK: begin
            lost_q <= lost_now;
            won_q  <= won_q | won_now;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_val = board_q[{rd_idx, 2'b00} +: 4];
  assign board  = board_q;
  assign score  = score_q;
  assign moved  = moved_q;
  assign done   = done_q;
  assign won    = won_q;
  assign lost   = lost_q;

endmodule
